// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and helpers for the data-memory responder.
// Default data width, responder FSM encoding and even-parity helper.
package cpu_pkg;

  localparam int DMEM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  // XOR of all bits; storing it makes the word's total parity even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: request/response channels between mem_access and
// the data-memory responder (master = initiator, slave = responder).
interface data_mem_resp_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: data storage, one write port and a registered read port.
// MEM_PARITY_EN adds a stored even-parity bit checked on every load.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  perr
);

`ifdef MEM_PARITY_EN
  localparam int WW = DATA_WIDTH + 1;
`else
  localparam int WW = DATA_WIDTH;
`endif

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] wword;
  logic [WW-1:0] rword;
  logic          rbad;

  assign rword = mem[addr];

  // Build the stored word, with parity bit on top when enabled.
  always_comb begin
`ifdef MEM_PARITY_EN
    wword = {even_par(64'(wdata)), wdata};
`else
    wword = wdata;
`endif
  end

  // Parity check of the addressed word.
  always_comb begin
`ifdef MEM_PARITY_EN
    rbad = ^rword;
`else
    rbad = 1'b0;
`endif
  end

  // Storage write port; contents are cleared by the owner after reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wword;
  end

  // Registered read port; stores echo their own data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      perr  <= 1'b0;
    end else if (en) begin
      if (we) begin
        rdata <= wdata;
        perr  <= 1'b0;
      end else begin
        rdata <= rword[DATA_WIDTH-1:0];
        perr  <= rbad;
      end
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: load/store responder with post-reset clear and wait states.
// Optional stored parity under MEM_PARITY_EN (see dmem_array).
module data_mem_resp
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus,
  output logic           init_busy
);

  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  dmem_state_t state;
  dmem_state_t state_nx;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  oor_q;

  logic                  accept;
  logic                  access;
  logic                  in_range;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;

  logic                  arr_en;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  arr_perr;

  assign accept = bus.req_valid & bus.req_ready;

  // With no wait states the access uses the request as it is accepted.
  assign cur_we    = NO_WAIT ? bus.req_we    : we_q;
  assign cur_addr  = NO_WAIT ? bus.req_addr  : addr_q;
  assign cur_wdata = NO_WAIT ? bus.req_wdata : wdata_q;

  assign in_range = 32'(cur_addr) < DEPTH;

  assign access = (state == WAIT && wait_cnt == 4'd0) ||
                  (NO_WAIT && accept);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_cnt == LAST) state_nx = IDLE;
      IDLE:  if (accept) state_nx = NO_WAIT ? RESP : WAIT;
      WAIT:  if (wait_cnt == 4'd0) state_nx = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          if (accept) state_nx = NO_WAIT ? RESP : WAIT;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    init_busy     = 1'b0;
    unique case (state)
      CLEAR: init_busy = 1'b1;
      IDLE:  bus.req_ready = 1'b1;
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.req_ready = bus.rsp_ready;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rdata = oor_q ? '0 : arr_rdata;
  assign bus.rsp_err   = oor_q | arr_perr;

  // Storage port: clear sweep during CLEAR, else the pending access.
  always_comb begin
    arr_en    = access & in_range;
    arr_we    = cur_we;
    arr_addr  = cur_addr;
    arr_wdata = cur_wdata;
    if (state == CLEAR) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
    end
  end

  // Clear counter, request capture, wait counter, range flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt  <= '0;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        wait_cnt <= WS_LOAD;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) oor_q <= ~in_range;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_arr (
    .clk   (clk),
    .rst   (rst),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata),
    .perr  (arr_perr)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed scoreboard bench, DEPTH=16 and DEPTH=12 units.
// Parity-corruption step runs when MEM_PARITY_EN is defined.
module tb_data_mem_resp;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  logic busy0;
  logic busy1;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  data_mem_resp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
  data_mem_resp_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b1 ();

  data_mem_resp #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_STATES(1)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .init_busy(busy0)
  );

  data_mem_resp #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .WAIT_STATES(1)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .init_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_rdy(input int u);
    return (u == 0) ? b0.req_ready : b1.req_ready;
  endfunction

  function automatic logic f_vld(input int u);
    return (u == 0) ? b0.rsp_valid : b1.rsp_valid;
  endfunction

  function automatic logic [7:0] f_data(input int u);
    return (u == 0) ? b0.rsp_rdata : b1.rsp_rdata;
  endfunction

  function automatic logic f_err(input int u);
    return (u == 0) ? b0.rsp_err : b1.rsp_err;
  endfunction

  task automatic drive(input int u, input logic v, input logic we,
                       input logic [3:0] a, input logic [7:0] d);
    if (u == 0) begin
      b0.req_valid = v; b0.req_we = we;
      b0.req_addr = a;  b0.req_wdata = d;
    end else begin
      b1.req_valid = v; b1.req_we = we;
      b1.req_addr = a;  b1.req_wdata = d;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input int u, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(f_data(u)), 32'(e.data));
      chk({tag, "_err"}, 32'(f_err(u)), 32'(e.err));
    end
  endtask

  task automatic wait_rdy(input int u, input string tag);
    int n;
    n = 0;
    while (!f_rdy(u) && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_acc"}, 32'(f_rdy(u)), 32'd1);
  endtask

  task automatic wait_vld(input int u, input string tag, input int lat);
    int n;
    n = 1;
    while (!f_vld(u) && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, n, lat);
  endtask

  // One complete transaction with rsp_ready high.
  task automatic xact(input int u, input logic we, input logic [3:0] a,
                      input logic [7:0] d, input logic [7:0] ed,
                      input logic ee, input string tag);
    drive(u, 1'b1, we, a, d);
    sb.push_back('{ed, ee});
    wait_rdy(u, tag);
    @(negedge clk);
    drive(u, 1'b0, 1'b0, 4'd0, 8'd0);
    wait_vld(u, tag, 2);
    pop_chk(u, tag);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int c1;
    int n;
    logic rdy_seen;
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    b0.rsp_ready = 1'b1;
    b1.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_rdy0", 32'(b0.req_ready), 0);
    chk("rst_vld0", 32'(b0.rsp_valid), 0);
    chk("rst_data0", 32'(b0.rsp_rdata), 0);
    chk("rst_err0", 32'(b0.rsp_err), 0);
    chk("rst_busy0", 32'(busy0), 1);
    chk("rst_busy1", 32'(busy1), 1);

    rst = 1'b1;
    c0 = 0;
    c1 = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if ((busy0 && b0.req_ready) || (busy1 && b1.req_ready))
        rdy_seen = 1'b1;
      @(negedge clk);
    end
    chk("clr_cycles0", c0, 16);
    chk("clr_cycles1", c1, 12);
    chk("clr_no_rdy", 32'(rdy_seen), 0);

    xact(0, 1'b0, 4'd0, 8'd0, 8'h00, 1'b0, "init_ld0");
    xact(0, 1'b0, 4'd15, 8'd0, 8'h00, 1'b0, "init_ld15");
    xact(1, 1'b0, 4'd11, 8'd0, 8'h00, 1'b0, "init_u1_ld11");

    xact(0, 1'b1, 4'd3, 8'hA5, 8'hA5, 1'b0, "st3");
    xact(0, 1'b0, 4'd3, 8'd0, 8'hA5, 1'b0, "ld3");

    xact(0, 1'b1, 4'd1, 8'h11, 8'h11, 1'b0, "st1");
    xact(0, 1'b1, 4'd2, 8'h22, 8'h22, 1'b0, "st2");
    drive(0, 1'b1, 1'b0, 4'd1, 8'd0);
    sb.push_back('{8'h11, 1'b0});
    wait_rdy(0, "b2b1");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'd2, 8'd0);
    sb.push_back('{8'h22, 1'b0});
    chk("b2b_wait_rdy", 32'(f_rdy(0)), 0);
    @(negedge clk);
    chk("b2b_vld1", 32'(f_vld(0)), 1);
    chk("b2b_rdy_in_resp", 32'(f_rdy(0)), 1);
    pop_chk(0, "b2b1");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    chk("b2b_no_idle", 32'(f_rdy(0)), 0);
    @(negedge clk);
    chk("b2b_vld2", 32'(f_vld(0)), 1);
    pop_chk(0, "b2b2");
    @(negedge clk);

    xact(0, 1'b1, 4'd9, 8'h5A, 8'h5A, 1'b0, "st9");
    b0.rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd9, 8'd0);
    sb.push_back('{8'h5A, 1'b0});
    wait_rdy(0, "stall");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'd3, 8'd0);
    sb.push_back('{8'hA5, 1'b0});
    wait_vld(0, "stall", 2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(f_vld(0)), 1);
      chk("stall_data", 32'(f_data(0)), 32'h5A);
      chk("stall_rdy", 32'(f_rdy(0)), 0);
      @(negedge clk);
    end
    b0.rsp_ready = 1'b1;
    pop_chk(0, "stall1");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    wait_vld(0, "stall2", 2);
    pop_chk(0, "stall2");
    @(negedge clk);

    xact(1, 1'b1, 4'd11, 8'h77, 8'h77, 1'b0, "oor_st11");
    xact(1, 1'b1, 4'd13, 8'hFF, 8'h00, 1'b1, "oor_st13");
    xact(1, 1'b0, 4'd13, 8'd0, 8'h00, 1'b1, "oor_ld13");
    xact(1, 1'b0, 4'd12, 8'd0, 8'h00, 1'b1, "oor_ld12");
    for (int a = 0; a < 12; a++) begin
      xact(1, 1'b0, 4'(a), 8'd0, (a == 11) ? 8'h77 : 8'h00, 1'b0,
           $sformatf("oor_keep%0d", a));
    end

    drive(0, 1'b1, 1'b1, 4'd5, 8'h3C);
    wait_rdy(0, "rst_st5");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(b0.rsp_valid), 0);
    chk("rst_mid_busy", 32'(busy0), 1);
    @(negedge clk);
    chk("rst_mid_vld2", 32'(b0.rsp_valid), 0);
    rst = 1'b1;
    n = 0;
    while (busy0 && n < 40) begin
      chk("reclr_vld", 32'(b0.rsp_valid), 0);
      @(negedge clk);
      n++;
    end
    chk("reclr_done", 32'(busy0), 0);
    xact(0, 1'b0, 4'd5, 8'd0, 8'h00, 1'b0, "rst_ld5");
    xact(0, 1'b0, 4'd3, 8'd0, 8'h00, 1'b0, "rst_ld3");

`ifdef MEM_PARITY_EN
    xact(0, 1'b1, 4'd7, 8'h3C, 8'h3C, 1'b0, "par_st7");
    u0.u_arr.mem[7][8] = ~u0.u_arr.mem[7][8];
    xact(0, 1'b0, 4'd7, 8'd0, 8'h3C, 1'b1, "par_ld7");
    xact(0, 1'b0, 4'd6, 8'd0, 8'h00, 1'b0, "par_ld6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
